// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results come from a combinational
// core on the latched operands and are committed when the latency counter expires.
module mul_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             d_use_md,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   b_safe, quo_s, rem_s, quo_u, rem_u;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               div_zero, is_md;

  assign is_md = ~op[2];
  assign busy  = (state_q == S_BUSY);
  assign stall = d_use_md & (busy | (start & is_md));
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Signed product via sign extension; only the low 2*WIDTH bits are kept.
  always_comb begin
    prod_s   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_zero = (b_q == '0);
    // Divisor 1 stands in for zero and for -1 on the most negative dividend;
    // the latter then yields exactly the required quotient MIN, remainder 0.
    b_safe   = (div_zero || (a_q == {1'b1, {(WIDTH-1){1'b0}}} && b_q == '1))
               ? WIDTH'(1) : b_q;
    quo_s    = $signed(a_q) / $signed(b_safe);
    rem_s    = $signed(a_q) % $signed(b_safe);
    quo_u    = a_q / b_safe;
    rem_u    = a_q % b_safe;
    res_hi   = '0;
    res_lo   = '0;
    case (op_q)
      2'b00: begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
      2'b01: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
      2'b10: begin res_hi = rem_s; res_lo = quo_s; end
      default: begin res_hi = rem_u; res_lo = quo_u; end
    endcase
    if (op_q[1] && div_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_md) begin
            a_d     = src_a;
            b_d     = src_b;
            op_d    = op[1:0];
            cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d = S_BUSY;
          end else if (op == OP_MTHI) begin
            hi_d = src_a;
          end else if (op == OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected {hi,lo} per MD op.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         d_use_md;
  logic         busy, stall;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic [W-1:0] hi_m = '0, lo_m = '0;

  mul_div_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .d_use_md(d_use_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one MD op, watch the busy window, then pop and compare the result.
  task automatic run_md(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic dmd, input logic [63:0] exp,
                        input int lat, input logic mthi_mid);
    int cyc;
    logic [63:0] e;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; d_use_md = dmd;
    #3 chk({tag, " stall@issue"}, 64'(stall), 64'(dmd));
    @(posedge clk); #1;
    if (mthi_mid) begin
      op = 3'b100; src_a = 32'hAAAA0000;
    end else begin
      start = 1'b0;
    end
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 40) begin
      cyc++;
      chk({tag, " stall@busy"}, 64'(stall), 64'(dmd));
      chk({tag, " hold"}, {hi, lo}, {hi_m, lo_m});
      if (cyc == 3) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy cycles"}, 64'(cyc), 64'(lat));
    chk({tag, " stall after"}, 64'(stall), 64'(0));
    e = sb.pop_front();
    chk({tag, " result"}, {hi, lo}, e);
    hi_m = e[63:32];
    lo_m = e[31:0];
  endtask

  task automatic run_mt(input string tag, input logic [2:0] o, input logic [W-1:0] a);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; d_use_md = 1'b1;
    #3 chk({tag, " stall"}, 64'(stall), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 3'b100) hi_m = a;
    else if (o == 3'b101) lo_m = a;
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " hilo"}, {hi, lo}, {hi_m, lo_m});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [63:0]  pu;
    reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; d_use_md = 1'b0;
    #2;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset hilo", {hi, lo}, 64'(0));
    #20 reset = 1'b1;

    run_md("mult",  3'b000, 32'hFFFFFFFF, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 5, 1'b0);
    run_md("multu", 3'b001, 32'hFFFFFFFF, 32'h2, 1'b0, 64'h00000001_FFFFFFFE, 5, 1'b0);
    run_md("div",   3'b010, 32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b0);
    run_md("divu",  3'b011, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, 10, 1'b0);
    run_md("divu0", 3'b011, 32'h1234, 32'h0, 1'b1, 64'h00001234_FFFFFFFF, 10, 1'b0);
    run_md("divovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 10, 1'b0);
    run_md("mult+mthi", 3'b000, 32'd1000, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFF448, 5, 1'b1);
    run_md("div pos", 3'b010, 32'd7, 32'hFFFFFFFE, 1'b0, {32'd1, 32'hFFFFFFFD}, 10, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      pu = {32'b0, ra} * {32'b0, rb};
      run_md("rnd multu", 3'b001, ra, rb, 1'b1, pu, 5, 1'b0);
      if (rb == 0) rb = 32'd3;
      run_md("rnd divu", 3'b011, ra, rb, 1'b0, {ra % rb, ra / rb}, 10, 1'b0);
    end

    run_mt("mthi", 3'b100, 32'h0BADF00D);
    run_mt("mtlo", 3'b101, 32'h12345678);
    run_mt("nop110", 3'b110, 32'hDEADBEEF);
    run_mt("nop111", 3'b111, 32'hDEADBEEF);

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; op = 3'b010; src_a = 32'd99; src_b = 32'd5; d_use_md = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre-reset busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("midreset busy", 64'(busy), 64'(0));
    chk("midreset stall", 64'(stall), 64'(0));
    chk("midreset hilo", {hi, lo}, 64'(0));
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    run_mt("post-reset mtlo", 3'b101, 32'h55);
    chk("post-reset queue", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage; owns the HI/LO architectural registers.
- Generates the stall signal consumed by the stall-capable pipeline registers upstream (F/D and D/E).
- While it is busy, any instruction that touches HI/LO is held in decode.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles from accepted multiply to HI/LO valid (≥1).
- DIV_CYCLES, 10, cycles from accepted divide to HI/LO valid (≥1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is a MD op; qualifies op.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
- src_a  input  WIDTH  rs operand (multiplicand/dividend/MT data).
- src_b  input  WIDTH  rt operand (multiplier/divisor).
- d_use_md  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- busy  output  1  operation in flight.
- stall  output  1  to pipeline register stall inputs.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async, any state): state IDLE, counter 0, busy=0, hi=0, lo=0, latched operands 0; in-flight operation discarded.
- States: IDLE, BUSY.
- IDLE, start=1 and op in {MULT,MULTU,DIV,DIVU} at edge N:
  - Latch src_a, src_b and op.
  - Load counter with L = MULT_CYCLES (mult) or DIV_CYCLES (div).
  - Enter BUSY; busy=1 after edge N.
- BUSY: counter decrements each edge. At edge N+L:
  - hi/lo take the result.
  - busy falls to 0 on the same edge; return to IDLE.
  - busy is high exactly L cycles.
- hi/lo hold their previous values throughout BUSY; there are no intermediate values on the outputs.
- IDLE, start=1, op=MTHI: hi<=src_a at next edge; lo unchanged; no busy. op=MTLO likewise for lo.
- start=1 while BUSY: ignored, any op; no restart, no MT write. Upstream stall prevents this case; the bench still checks it.
- start=1 with op 110/111: no-op.
- Arithmetic:
  - MULT: signed 2·WIDTH product; hi=upper half, lo=lower half.
  - MULTU: same, unsigned.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - Divide by zero (DIV or DIVU): lo=all ones, hi=src_a, same latency.
  - Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): lo=0x80000000, hi=0.
- Implementation is free (iterative or combinational core plus delay) provided latency and results are exact.
- stall (combinational) = d_use_md & (busy | (start & op∈{MULT,MULTU,DIV,DIVU})).
  - Stall asserts in the same cycle the op is issued.
  - Stall deasserts in the cycle after the edge where hi/lo update, so MFHI/MFLO reads fresh values.
- MTHI/MTLO never cause stall.
- d_use_md=0 never stalls, even while busy.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-stream -> busy=0, stall=0, hi=lo=0 immediately, without waiting for a clock edge.
- MULT src_a=0xFFFFFFFF, src_b=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- Boundary cases:
  - DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall/issue interaction:
  - Issue MULT with d_use_md=1 held -> stall=1 from the issue cycle through the 5th busy cycle, 0 the cycle after.
  - With d_use_md=0 -> stall stays 0.
  - MTHI 0xAAAA0000 issued while busy -> ignored; final hi is the multiply result.
- Reset mid-op: start DIV, assert reset at busy cycle 4 -> busy=0, hi=lo=0; after release, MTLO 0x55 -> lo=0x55 next edge, hi=0.
